// File: rtl/exec_issue_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// exec_issue_ctrl_pkg
//   Shared definitions for the SIMD execute-unit front-end sequencer:
//   - OP_SEL_WIDTH : width of the PE operation selector
//   - dot_ctrl_e   : dot-product accumulator control encoding
//   - state_e      : sequencer FSM states
//   - sat_beats    : clamps a requested beat count to the supported maximum
// ---------------------------------------------------------------------------
package exec_issue_ctrl_pkg;

  localparam int OP_SEL_WIDTH = 3;

  // DOT_LOAD clears the accumulator and accumulates the current beat in one go.
  typedef enum logic [1:0] {
    DOT_NOP  = 2'b00,
    DOT_CLR  = 2'b01,
    DOT_ACC  = 2'b10,
    DOT_LOAD = 2'b11
  } dot_ctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  function automatic int unsigned sat_beats(input int unsigned req,
                                            input int unsigned max_beats);
    return (req > max_beats) ? max_beats : req;
  endfunction

endpackage

// File: rtl/exec_issue_ctrl.sv
// ---------------------------------------------------------------------------
// exec_issue_ctrl
//   Front-end sequencer for the SIMD execute unit. Accepts one vector command,
//   pulls operand beats, presents them to the execute unit together with
//   exe_half_clk / exe_pe_op / exe_dot_ctrl, and captures the elementwise or
//   dot-product result into a backpressured result port.
//
// Ports
//   clk, rstn                 clock, synchronous active-low reset
//   cmd_valid/cmd_ready       command handshake (cmd_op, cmd_dot, cmd_beats)
//   opd_valid/opd_ready       operand beat handshake (opd_a, opd_b)
//   exe_a, exe_b, exe_pe_op   operand vectors and operation to execute unit
//   exe_dot_ctrl              accumulator control (NOP/CLR/ACC/LOAD)
//   exe_half_clk              free-running half-rate phase to execute unit
//   exe_elem_out, exe_dot_out results returned by the execute unit
//   res_valid/res_ready       result handshake (res_data, res_is_dot)
//   busy                      a command is in progress
// ---------------------------------------------------------------------------
module exec_issue_ctrl
  import exec_issue_ctrl_pkg::*;
#(
  parameter int PE_COUNT   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BEATS  = 16,
  parameter int DOT_LAT    = 2
) (
  input  logic                               clk,
  input  logic                               rstn,
  // command port
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic [OP_SEL_WIDTH-1:0]            cmd_op,
  input  logic                               cmd_dot,
  input  logic [$clog2(MAX_BEATS+1)-1:0]     cmd_beats,
  // operand stream
  input  logic                               opd_valid,
  output logic                               opd_ready,
  input  logic [PE_COUNT*DATA_WIDTH-1:0]     opd_a,
  input  logic [PE_COUNT*DATA_WIDTH-1:0]     opd_b,
  // execute unit interface
  output logic [PE_COUNT*DATA_WIDTH-1:0]     exe_a,
  output logic [PE_COUNT*DATA_WIDTH-1:0]     exe_b,
  output logic [OP_SEL_WIDTH-1:0]            exe_pe_op,
  output logic [1:0]                         exe_dot_ctrl,
  output logic                               exe_half_clk,
  input  logic [PE_COUNT*DATA_WIDTH-1:0]     exe_elem_out,
  input  logic [PE_COUNT*DATA_WIDTH-1:0]     exe_dot_out,
  // result port
  output logic                               res_valid,
  input  logic                               res_ready,
  output logic [PE_COUNT*DATA_WIDTH-1:0]     res_data,
  output logic                               res_is_dot,
  output logic                               busy
);

  localparam int VEC_W  = PE_COUNT * DATA_WIDTH;
  localparam int BEAT_W = $clog2(MAX_BEATS + 1);
  // Holds 0..DOT_LAT+1 so the wait counter never wraps before capture.
  localparam int LAT_W  = $clog2(DOT_LAT + 2);

  state_e              state_q, state_d;
  logic                half_clk_q;
  logic [OP_SEL_WIDTH-1:0] op_q;
  logic                dot_q;
  logic                first_q;
  logic [BEAT_W-1:0]   cnt_q, cnt_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  dot_ctrl_e           dot_ctrl_q, dot_ctrl_d;
  logic [VEC_W-1:0]    exe_a_q, exe_b_q;
  logic [OP_SEL_WIDTH-1:0] exe_op_q;
  logic                res_valid_q;
  logic [VEC_W-1:0]    res_data_q;
  logic                res_is_dot_q;

  logic                cmd_hs, opd_hs, res_hs;
  logic                last_beat;
  logic                capture;

  // Ready outputs are gated by rstn so every output reads 0 while reset is held.
  assign cmd_ready = rstn && (state_q == ST_IDLE);
  // Operands are only taken in half_clk=0 cycles so each beat is presented to
  // the execute unit in the following half_clk=1 cycle.
  assign opd_ready = rstn && (state_q == ST_ISSUE) && !half_clk_q;

  assign cmd_hs    = cmd_valid && cmd_ready;
  assign opd_hs    = opd_valid && opd_ready;
  assign res_hs    = res_valid_q && res_ready;
  assign last_beat = (cnt_q == '0);

  // Elementwise: the registered result is valid one cycle after the beat's C1.
  // Dot: only the last beat produces a result, DOT_LAT cycles after its C1.
  assign capture = (state_q == ST_WAIT) &&
                   (dot_q ? (last_beat && (lat_q == LAT_W'(DOT_LAT)))
                          : (lat_q == LAT_W'(1)));

  // ---- next-state / control decode ----
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lat_d      = '0;
    dot_ctrl_d = DOT_NOP;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_hs) begin
          cnt_d = BEAT_W'(sat_beats(32'(cmd_beats), MAX_BEATS));
          if (cmd_beats != '0) state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (opd_hs) begin
          cnt_d   = cnt_q - 1'b1;
          state_d = ST_WAIT;
          if (dot_q) dot_ctrl_d = first_q ? DOT_LOAD : DOT_ACC;
        end
      end
      ST_WAIT: begin
        lat_d = lat_q + 1'b1;
        // Intermediate dot beats need no result, so the next operand can be
        // taken right after C1.
        if (dot_q && !last_beat) state_d = ST_ISSUE;
        else if (capture)        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (res_hs) state_d = last_beat ? ST_IDLE : ST_ISSUE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // ---- datapath and control registers ----
  always_ff @(posedge clk) begin
    if (!rstn) begin
      half_clk_q   <= 1'b0;
      op_q         <= '0;
      dot_q        <= 1'b0;
      first_q      <= 1'b0;
      cnt_q        <= '0;
      lat_q        <= '0;
      dot_ctrl_q   <= DOT_NOP;
      exe_a_q      <= '0;
      exe_b_q      <= '0;
      exe_op_q     <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_is_dot_q <= 1'b0;
    end else begin
      half_clk_q <= ~half_clk_q;
      cnt_q      <= cnt_d;
      lat_q      <= lat_d;
      dot_ctrl_q <= dot_ctrl_d;

      if (cmd_hs) begin
        op_q    <= cmd_op;
        dot_q   <= cmd_dot;
        first_q <= 1'b1;
      end

      if (opd_hs) begin
        exe_a_q  <= opd_a;
        exe_b_q  <= opd_b;
        exe_op_q <= op_q;
        first_q  <= 1'b0;
      end

      if (capture) begin
        res_valid_q  <= 1'b1;
        res_data_q   <= dot_q ? exe_dot_out : exe_elem_out;
        res_is_dot_q <= dot_q;
      end else if (res_hs) begin
        res_valid_q  <= 1'b0;
      end
    end
  end

  assign exe_a        = exe_a_q;
  assign exe_b        = exe_b_q;
  assign exe_pe_op    = exe_op_q;
  assign exe_dot_ctrl = dot_ctrl_q;
  assign exe_half_clk = half_clk_q;
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign res_is_dot   = res_is_dot_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_exec_issue_ctrl.sv
`timescale 1ns/1ps
module tb_exec_issue_ctrl;
  import exec_issue_ctrl_pkg::*;

  localparam int PE   = 4;
  localparam int DW   = 32;
  localparam int MAXB = 16;
  localparam int DLAT = 2;
  localparam int VW   = PE * DW;
  localparam int BW   = $clog2(MAXB + 1);

  localparam logic [OP_SEL_WIDTH-1:0] OP_ADD = 3'd0;
  localparam logic [OP_SEL_WIDTH-1:0] OP_SUB = 3'd1;
  localparam logic [OP_SEL_WIDTH-1:0] OP_XOR = 3'd2;

  logic clk = 1'b0;
  logic rstn;
  logic cmd_valid, cmd_ready, cmd_dot;
  logic [OP_SEL_WIDTH-1:0] cmd_op;
  logic [BW-1:0] cmd_beats;
  logic opd_valid, opd_ready;
  logic [VW-1:0] opd_a, opd_b, exe_a, exe_b, elem_out, dot_out, res_data;
  logic [OP_SEL_WIDTH-1:0] exe_pe_op;
  logic [1:0] exe_dot_ctrl;
  logic exe_half_clk, res_valid, res_ready, res_is_dot, busy;

  exec_issue_ctrl #(.PE_COUNT(PE), .DATA_WIDTH(DW), .MAX_BEATS(MAXB), .DOT_LAT(DLAT)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_dot(cmd_dot),
    .cmd_beats(cmd_beats),
    .opd_valid(opd_valid), .opd_ready(opd_ready), .opd_a(opd_a), .opd_b(opd_b),
    .exe_a(exe_a), .exe_b(exe_b), .exe_pe_op(exe_pe_op), .exe_dot_ctrl(exe_dot_ctrl),
    .exe_half_clk(exe_half_clk), .exe_elem_out(elem_out), .exe_dot_out(dot_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_is_dot(res_is_dot), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [VW-1:0] lane_op(input logic [OP_SEL_WIDTH-1:0] op,
                                            input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [VW-1:0] r;
    r = '0;
    for (int i = 0; i < PE; i++) begin
      case (op)
        OP_ADD:  r[i*DW +: DW] = a[i*DW +: DW] + b[i*DW +: DW];
        OP_SUB:  r[i*DW +: DW] = a[i*DW +: DW] - b[i*DW +: DW];
        default: r[i*DW +: DW] = a[i*DW +: DW] ^ b[i*DW +: DW];
      endcase
    end
    return r;
  endfunction

  // Execute unit: registered elementwise path, dot stub valid DLAT cycles
  // after each accumulate cycle and garbage otherwise.
  logic [DLAT-1:0] dsh = '0;
  always @(posedge clk) begin
    elem_out <= lane_op(exe_pe_op, exe_a, exe_b);
    dsh      <= {dsh[DLAT-2:0], exe_dot_ctrl != 2'b00};
  end
  assign dot_out = dsh[DLAT-1] ? {PE{32'h0000CAFE}} : {PE{32'hBAD0BAD0}};

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ------------------------------------------------------------------
  // Transaction-level model: beats remaining, timestamps of the next
  // allowed operand, the pending result and the dot_ctrl cycle.
  // ------------------------------------------------------------------
  bit m_known = 0;
  bit m_half, m_dot, m_first, m_res_dot;
  int m_left, m_opd_from, m_res_at, m_ctrl_at, m_n;
  logic [OP_SEL_WIDTH-1:0] m_op, m_exe_op;
  logic [1:0] m_ctrl_val;
  logic [VW-1:0] m_a, m_b, m_res;
  bit e_act, e_cmd, e_opd, e_res;
  logic [2:0] ctrl_log[$];

  always @(negedge clk) begin
    e_act = 0; e_cmd = 0; e_opd = 0; e_res = 0;
    if (m_known) begin
      e_act = (m_left > 0) || (m_res_at >= 0);
      e_cmd = rstn && !e_act;
      e_opd = rstn && (m_left > 0) && (m_res_at < 0) && (cyc >= m_opd_from) && !m_half;
      e_res = (m_res_at >= 0) && (cyc >= m_res_at);
      chk("m_half_clk",  VW'(exe_half_clk), VW'(m_half));
      chk("m_cmd_ready", VW'(cmd_ready), VW'(e_cmd));
      chk("m_opd_ready", VW'(opd_ready), VW'(e_opd));
      chk("m_busy",      VW'(busy), VW'(e_act));
      chk("m_res_valid", VW'(res_valid), VW'(e_res));
      chk("m_dot_ctrl",  VW'(exe_dot_ctrl), VW'((cyc == m_ctrl_at) ? m_ctrl_val : 2'b00));
      chk("m_exe_a",     exe_a, m_a);
      chk("m_exe_b",     exe_b, m_b);
      chk("m_exe_op",    VW'(exe_pe_op), VW'(m_exe_op));
      if (e_res) begin
        chk("m_res_data",   res_data, m_res);
        chk("m_res_is_dot", VW'(res_is_dot), VW'(m_res_dot));
      end
    end
    if (exe_dot_ctrl != 2'b00) ctrl_log.push_back({exe_half_clk, exe_dot_ctrl});
    if (!rstn) begin
      m_known = 1; m_half = 0; m_left = 0; m_res_at = -1; m_ctrl_at = -1;
      m_opd_from = 0; m_a = '0; m_b = '0; m_exe_op = '0; m_first = 0;
      m_res = '0; m_res_dot = 0; m_dot = 0; m_op = '0; m_ctrl_val = 2'b00;
    end else if (m_known) begin
      m_half = !m_half;
      if (cmd_valid && e_cmd) begin
        m_n = int'(cmd_beats);
        if (m_n > MAXB) m_n = MAXB;
        if (m_n > 0) begin
          m_left = m_n; m_first = 1; m_dot = cmd_dot; m_op = cmd_op; m_opd_from = cyc + 1;
        end
      end
      if (opd_valid && e_opd) begin
        m_a = opd_a; m_b = opd_b; m_exe_op = m_op; m_ctrl_at = cyc + 1;
        m_ctrl_val = m_dot ? (m_first ? 2'b11 : 2'b10) : 2'b00;
        m_first = 0;
        m_left--;
        if (!m_dot) begin
          m_res_at = cyc + 3; m_res = lane_op(m_op, opd_a, opd_b); m_res_dot = 0;
        end else if (m_left > 0) begin
          m_opd_from = cyc + 2;
        end else begin
          m_res_at = cyc + 2 + DLAT; m_res = {PE{32'h0000CAFE}}; m_res_dot = 1;
        end
      end
      if (e_res && res_ready) begin
        m_res_at = -1; m_opd_from = cyc + 1;
      end
    end
  end

  // ------------------------------------------------------------------
  // Stimulus helpers: inputs change 1ns after a rising edge.
  // ------------------------------------------------------------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_cmd(input logic [OP_SEL_WIDTH-1:0] op, input logic dot, input logic [BW-1:0] beats);
    bit ok;
    ok = 0;
    cmd_op = op; cmd_dot = dot; cmd_beats = beats; cmd_valid = 1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1;
    end
    if (!ok) chk("cmd_accept_timeout", VW'(ok), VW'(1));
    tick();
    cmd_valid = 0;
  endtask

  task automatic send_opd(input logic [VW-1:0] a, input logic [VW-1:0] b, output int hs);
    bit ok;
    ok = 0; hs = 0;
    opd_a = a; opd_b = b; opd_valid = 1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (opd_ready) begin ok = 1; hs = cyc; end
    end
    if (!ok) chk("opd_accept_timeout", VW'(ok), VW'(1));
    tick();
    opd_valid = 0;
  endtask

  // Returns at the falling edge of the first cycle with res_valid high.
  task automatic wait_res(output int rc);
    bit ok;
    ok = 0; rc = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (res_valid) begin ok = 1; rc = cyc; end
    end
    if (!ok) chk("res_valid_timeout", VW'(ok), VW'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int h, h3, r;
    logic [VW-1:0] a, b, hold;
    rstn = 0; cmd_valid = 0; cmd_op = '0; cmd_dot = 0; cmd_beats = '0;
    opd_valid = 0; opd_a = '0; opd_b = '0; res_ready = 0;

    // 1: reset held for several edges, then free-running half_clk
    repeat (3) @(negedge clk);
    chk("rst_exe_a", exe_a, '0);
    chk("rst_exe_b", exe_b, '0);
    chk("rst_pe_op", VW'(exe_pe_op), '0);
    chk("rst_dot_ctrl", VW'(exe_dot_ctrl), '0);
    chk("rst_half_clk", VW'(exe_half_clk), '0);
    chk("rst_res_valid", VW'(res_valid), '0);
    chk("rst_res_data", res_data, '0);
    chk("rst_res_is_dot", VW'(res_is_dot), '0);
    chk("rst_busy", VW'(busy), '0);
    chk("rst_cmd_ready", VW'(cmd_ready), '0);
    chk("rst_opd_ready", VW'(opd_ready), '0);
    tick();
    rstn = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("half_clk_seq", VW'(exe_half_clk), VW'(k % 2));
      chk("idle_cmd_ready", VW'(cmd_ready), VW'(1));
    end
    tick();

    // 2: elementwise ADD, one beat
    res_ready = 1;
    send_cmd(OP_ADD, 1'b0, BW'(1));
    send_opd({32'd4, 32'd3, 32'd2, 32'd1}, {32'd40, 32'd30, 32'd20, 32'd10}, h);
    wait_res(r);
    chk("elem_latency", VW'(r - h), VW'(3));
    chk("elem_data", res_data, {32'd44, 32'd33, 32'd22, 32'd11});
    chk("elem_is_dot", VW'(res_is_dot), VW'(0));
    tick();
    @(negedge clk);
    chk("elem_done_busy", VW'(busy), VW'(0));
    chk("elem_done_cmd_ready", VW'(cmd_ready), VW'(1));
    tick();

    // 3: dot product, three beats
    ctrl_log.delete();
    send_cmd(OP_ADD, 1'b1, BW'(3));
    send_opd({PE{32'd1}}, {PE{32'd2}}, h);
    send_opd({PE{32'd3}}, {PE{32'd4}}, h);
    send_opd({PE{32'd5}}, {PE{32'd6}}, h3);
    wait_res(r);
    chk("dot_latency", VW'(r - (h3 + 1)), VW'(3));
    chk("dot_data", res_data, {PE{32'h0000CAFE}});
    chk("dot_is_dot", VW'(res_is_dot), VW'(1));
    tick();
    chk("dot_ctrl_count", VW'(ctrl_log.size()), VW'(3));
    for (int i = 0; i < 3; i++)
      chk("dot_ctrl_seq", VW'((i < ctrl_log.size()) ? ctrl_log[i] : 3'b000),
          VW'((i == 0) ? 3'b111 : 3'b110));

    // 4: elementwise SUB, two beats, result backpressured
    res_ready = 0;
    send_cmd(OP_SUB, 1'b0, BW'(2));
    send_opd({32'd400, 32'd300, 32'd200, 32'd100}, {32'd4, 32'd3, 32'd2, 32'd1}, h);
    wait_res(r);
    chk("bp_latency", VW'(r - h), VW'(3));
    hold = {32'd396, 32'd297, 32'd198, 32'd99};
    chk("bp_data", res_data, hold);
    tick();
    opd_a = {32'd40, 32'd30, 32'd20, 32'd10}; opd_b = {PE{32'd1}}; opd_valid = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", VW'(res_valid), VW'(1));
      chk("bp_hold_data", res_data, hold);
      chk("bp_no_opd_ready", VW'(opd_ready), VW'(0));
    end
    tick();
    res_ready = 1;
    @(negedge clk);
    tick();
    res_ready = 0;
    begin
      bit ok;
      ok = 0;
      for (int i = 0; i < 10 && !ok; i++) begin
        @(negedge clk);
        if (opd_ready) ok = 1;
      end
      chk("bp_second_opd", VW'(ok), VW'(1));
    end
    tick();
    opd_valid = 0;
    res_ready = 1;
    wait_res(r);
    chk("bp_second_data", res_data, {32'd39, 32'd29, 32'd19, 32'd9});
    tick();
    @(negedge clk);
    chk("bp_done_busy", VW'(busy), VW'(0));
    tick();

    // 5: zero-beat command
    send_cmd(OP_ADD, 1'b0, BW'(0));
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("zero_opd_ready", VW'(opd_ready), VW'(0));
      chk("zero_res_valid", VW'(res_valid), VW'(0));
      chk("zero_cmd_ready", VW'(cmd_ready), VW'(1));
      chk("zero_busy", VW'(busy), VW'(0));
    end
    tick();

    // beat count above MAX_BEATS saturates
    send_cmd(OP_XOR, 1'b0, BW'(20));
    for (int i = 0; i < MAXB; i++) begin
      a = {PE{32'(i * 3 + 1)}};
      b = {PE{32'h0000_00F0}};
      send_opd(a, b, h);
      wait_res(r);
      chk("sat_data", res_data, a ^ b);
      tick();
    end
    @(negedge clk);
    chk("sat_idle_busy", VW'(busy), VW'(0));
    chk("sat_idle_cmd_ready", VW'(cmd_ready), VW'(1));
    tick();

    // 6: reset pulse in the middle of a dot command
    send_cmd(OP_ADD, 1'b1, BW'(3));
    send_opd({PE{32'd7}}, {PE{32'd8}}, h);
    rstn = 0;
    tick();
    rstn = 1;
    @(negedge clk);
    chk("midrst_busy", VW'(busy), VW'(0));
    chk("midrst_dot_ctrl", VW'(exe_dot_ctrl), VW'(0));
    chk("midrst_res_valid", VW'(res_valid), VW'(0));
    chk("midrst_exe_a", exe_a, '0);
    chk("midrst_cmd_ready", VW'(cmd_ready), VW'(1));
    tick();
    send_cmd(OP_ADD, 1'b0, BW'(1));
    send_opd({32'd1, 32'd1, 32'd1, 32'd1}, {32'd2, 32'd3, 32'd4, 32'd5}, h);
    wait_res(r);
    chk("post_rst_latency", VW'(r - h), VW'(3));
    chk("post_rst_data", res_data, {32'd3, 32'd4, 32'd5, 32'd6});
    tick();
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/exec_issue_ctrl.md
Name: exec_issue_ctrl

Overview:
Front-end sequencer that drives the SIMD execute unit. It accepts one vector command over a valid/ready handshake, then pulls operand beats from an operand stream and presents them to the execute unit. It generates half_clk, pe_op and dot_ctrl for each beat and captures elementwise or dot-product results into a backpressured result port for writeback.

Parameters:
PE_COUNT, 4, lanes per vector
DATA_WIDTH, 32, bits per lane
MAX_BEATS, 16, max operand beats per command
DOT_LAT, 2, cycles from the end of the last accumulate cycle until exe_dot_out is valid

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when both high
cmd_op  in  OP_SEL_WIDTH  PE operation for all beats
cmd_dot  in  1  1 = dot-product command, 0 = elementwise
cmd_beats  in  $clog2(MAX_BEATS+1)  number of operand beats
opd_valid  in  1  operand beat offered
opd_ready  out  1  operand beat accepted when both high
opd_a, opd_b  in  PE_COUNT*DATA_WIDTH  operand vectors
exe_a, exe_b  out  PE_COUNT*DATA_WIDTH  to execute unit
exe_pe_op  out  OP_SEL_WIDTH  to execute unit
exe_dot_ctrl  out  2  to execute unit
exe_half_clk  out  1  to execute unit
exe_elem_out  in  PE_COUNT*DATA_WIDTH  registered elementwise result
exe_dot_out  in  PE_COUNT*DATA_WIDTH  dot-product result
res_valid  out  1  result offered
res_ready  in  1  result accepted when both high
res_data  out  PE_COUNT*DATA_WIDTH  captured result
res_is_dot  out  1  result came from a dot command
busy  out  1  state != IDLE

Behaviour:
- Reset: synchronous, active-low; rstn=0 on a clk edge takes effect at that edge.
  - Applies in any state, including mid-command. The in-flight command and any pending result are discarded.
  - After reset: state IDLE; every output 0, including exe_half_clk=0 and exe_dot_ctrl=DOT_NOP.
- exe_half_clk: free-running register, toggles every cycle after reset (0,1,0,1,...).
- dot_ctrl encoding: DOT_NOP=00, DOT_CLR=01, DOT_ACC=10, DOT_LOAD=11 (clear plus accumulate).
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - cmd_ready=1.
  - Handshake latches op, dot and beats, and sets beat counter = cmd_beats.
  - cmd_beats=0: stay in IDLE; no operands consumed, no result.
  - Otherwise go to ISSUE.
- ISSUE: opd_ready = (exe_half_clk==0). Operand handshake at edge E0 (a half_clk=0 cycle):
  - In the next cycle C1 (half_clk=1): exe_a/exe_b = operand; exe_pe_op = latched op.
  - exe_dot_ctrl in C1: DOT_LOAD for the first beat of a dot command, DOT_ACC for later dot beats, DOT_NOP for elementwise.
  - In all other cycles exe_dot_ctrl=DOT_NOP. exe_a/exe_b/exe_pe_op hold their last value.
  - Beat counter decrements at E0; then go to WAIT.
- WAIT, elementwise:
  - exe_elem_out is valid in cycle C2 (after edge E1).
  - res_data is captured at end of C2; res_valid=1 from C3.
  - Latency is 3 cycles from the operand handshake edge to res_valid. Go to RESP.
- WAIT, dot:
  - Not last beat: return to ISSUE immediately after C1.
  - Last beat: count DOT_LAT cycles after C1, capture exe_dot_out, res_valid next cycle, go to RESP.
- RESP:
  - res_valid held with res_data and res_is_dot stable until res_ready.
  - On handshake: counter>0 (elementwise) → ISSUE; else → IDLE.
  - res_valid and res_ready high in the same cycle that res_valid rises completes the handshake in that cycle.
- Backpressure: opd_ready is never asserted while a result is pending. At most one result is outstanding.
- cmd_beats > MAX_BEATS: saturated to MAX_BEATS.
- busy = (state != IDLE).

Decomposition:
- Shared package holds: the DOT_* encodings, a state enum typedef, and the OP_SEL_WIDTH constant (already defined there).
- No sub-module. The half_clk toggle and the latency counter are inline.

Test Plan:
1. Reset: hold rstn=0 for 3 cycles, then release → all outputs 0 during reset; exe_half_clk runs 0,1,0,1 after release; cmd_ready=1.
2. Elementwise ADD, beats=1, a={1,2,3,4}, b={10,20,30,40}, real execute unit attached → res_data={11,22,33,44}, res_is_dot=0, res_valid exactly 3 cycles after the opd handshake.
3. Dot, beats=3, execute stub returning 0xCAFE in all lanes → exe_dot_ctrl sequence LOAD,ACC,ACC, each only in a half_clk=1 cycle; res_data=0xCAFE per lane, res_is_dot=1, res_valid DOT_LAT+1 cycles after the third C1.
4. Elementwise, beats=2, res_ready held low 5 cycles → res_data stable; opd_ready stays 0 until the first result is accepted; the second result follows; then IDLE.
5. cmd_beats=0 → opd_ready never asserted, no res_valid, cmd_ready=1 on the following cycle.
6. rstn pulsed low mid-dot after beat 1 of 3 → state IDLE, exe_dot_ctrl=NOP, res_valid=0; a subsequent beats=1 command completes normally.
